// File: rtl/pkg_core.sv
// Shared types and widths for the register-file writeback arbiter.
package pkg_core;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // One register-file write: destination register and data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     val;
  } wb_req_t;

  // Starvation guard states: RUN lets A win freely, FORCE holds the pipeline
  // off the write port until the blocked B head is written.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FORCE = 1'b1
  } starve_state_e;

endpackage

// File: rtl/wb_res_fifo.sv
// Small in-order buffer of long-latency results waiting for a free write slot.
// Each entry carries a valid bit so a younger pipeline write to the same
// register can kill it in place without disturbing FIFO order. A killed entry
// still occupies its slot until it reaches the head and is popped.
module wb_res_fifo
  import pkg_core::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_en,
  input  wb_req_t               push_req,
  input  logic                  pop_en,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  input  logic [REG_ADDR_W-1:0] match_rd,
  output logic                  match_any,
  output logic                  full,
  output logic                  empty,
  output logic                  head_valid,
  output wb_req_t               head_req
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  wb_req_t          data_q [DEPTH];
  wb_req_t          data_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == '0);
  assign head_valid = valid_q[rd_ptr_q];
  assign head_req   = data_q[rd_ptr_q];

  // Any live entry targeting the queried register (register 0 never matches).
  always_comb begin
    match_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (data_q[i].rd == match_rd)) match_any = 1'b1;
    end
    if (match_rd == '0) match_any = 1'b0;
  end

  // Next-state: kill matching entries, pop the head, append the new entry.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (data_q[i].rd == kill_rd) valid_d[i] = 1'b0;
      end
    end
    if (pop_en) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_ONE;
    end
    if (push_en) begin
      valid_d[wr_ptr_q] = 1'b1;
      data_d[wr_ptr_q]  = push_req;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the buffer and drops every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback stage (A, always wins) and buffered long-latency results (B).
// Optional starvation guard enabled by defining WB_ARB_STARVE_EN; without it
// stall_pipe is tied low and B drains only in cycles where a_rd == 0.
//
// B handshake: a B result transfers on a rising edge where b_valid && b_ready
// are both high; b_ready depends only on registered occupancy, so a pop in the
// same cycle never raises it early. Results to r0, or to the register A is
// writing in that same cycle, are accepted but not stored.
module regfile_wb_arbiter
  import pkg_core::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0]     a_val,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0]     b_val,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  q_hit,
  output logic                  stall_pipe,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0]     reg_din,
  output logic                  reg_we
);

  if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("regfile_wb_arbiter: DEPTH must be a power of two in 2..8");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("regfile_wb_arbiter: STARVE_LIMIT must be in 1..255");
  end

  logic    sel_a, pop_en, push_en, accept;
  logic    fifo_full, fifo_empty, head_valid;
  wb_req_t head_req, push_req;

  logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]     reg_din_q, reg_din_d;
  logic                  reg_we_q, reg_we_d;

  assign b_ready  = !fifo_full;
  assign accept   = b_valid && b_ready;
  assign sel_a    = (a_rd != '0);
  assign pop_en   = !sel_a && !fifo_empty;
  // An incoming B is older than a same-cycle A write to its register.
  assign push_en  = accept && (b_rd != '0) && !(sel_a && (b_rd == a_rd));
  assign push_req = '{rd: b_rd, val: b_val};

  wb_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_en    (push_en),
    .push_req   (push_req),
    .pop_en     (pop_en),
    .kill_en    (sel_a),
    .kill_rd    (a_rd),
    .match_rd   (q_rd),
    .match_any  (q_hit),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_valid (head_valid),
    .head_req   (head_req)
  );

  // Write-port selection: A first, then a live FIFO head, otherwise idle.
  always_comb begin
    reg_we_d   = 1'b0;
    reg_addr_d = '0;
    reg_din_d  = '0;
    if (sel_a) begin
      reg_we_d   = 1'b1;
      reg_addr_d = a_rd;
      reg_din_d  = a_val;
    end else if (pop_en && head_valid) begin
      reg_we_d   = 1'b1;
      reg_addr_d = head_req.rd;
      reg_din_d  = head_req.val;
    end
  end

  // Registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_din_q  <= '0;
    end else begin
      reg_we_q   <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      reg_din_q  <= reg_din_d;
    end
  end

  assign reg_we   = reg_we_q;
  assign reg_addr = reg_addr_q;
  assign reg_din  = reg_din_q;

`ifdef WB_ARB_STARVE_EN
  starve_state_e state_q;
  logic [7:0]    starve_cnt_q;
  logic          stall_pipe_q;

  // Starvation FSM: count cycles a live head loses to A; at the limit, stall
  // the pipeline until a free slot writes the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      starve_cnt_q <= '0;
      stall_pipe_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (sel_a && !fifo_empty && head_valid) begin
            starve_cnt_q <= starve_cnt_q + 8'd1;
            if (starve_cnt_q == 8'(STARVE_LIMIT - 1)) begin
              state_q      <= ST_FORCE;
              stall_pipe_q <= 1'b1;
            end
          end else if (pop_en || fifo_empty) begin
            starve_cnt_q <= '0;
          end
        end
        ST_FORCE: begin
          // A still wins if the pipeline ignores the stall.
          if (!sel_a) begin
            state_q      <= ST_RUN;
            starve_cnt_q <= '0;
            stall_pipe_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_RUN;
          starve_cnt_q <= '0;
          stall_pipe_q <= 1'b0;
        end
      endcase
    end
  end

  assign stall_pipe = stall_pipe_q;
`else
  assign stall_pipe = 1'b0;
`endif

endmodule
